// File: rtl/fnd_page_ctrl.sv
// fnd_page_ctrl: page FSM/arbiter selecting the digit word for seven_segment_display,
// with edit-field blinking and a timed alert page.
module fnd_page_ctrl #(
    parameter int          BLINK_DIV   = 12800,
    parameter int          ALERT_TICKS = 10,
    parameter logic [23:0] ALERT_MSG   = 24'h112200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        mode_btn,
    input  logic        alert,
    input  logic        edit_active,
    input  logic [1:0]  edit_field,
    input  logic [23:0] time_disp,
    input  logic [23:0] alarm_disp,
    input  logic [23:0] sw_disp,
    output logic [23:0] display,
    output logic        blink,
    output logic [1:0]  page,
    output logic        alert_active
);
    typedef enum logic [1:0] {PG_TIME, PG_ALARM, PG_SW, PG_ALERT} page_t;
    page_t       state, state_n, saved, saved_n;
    logic [7:0]  acnt, acnt_n;
    logic [31:0] bcnt, bcnt_n;
    logic        hidden, hidden_n, edit_q, restart, wrap, blank_en;
    logic [1:0]  field_q;
    logic [23:0] src, disp_n;

    always_comb begin
        state_n = state;
        saved_n = saved;
        acnt_n  = acnt;
        if (state != PG_ALERT) begin
            if (alert) begin
                saved_n = state;
                state_n = PG_ALERT;
                acnt_n  = 8'(ALERT_TICKS);
            end else if (mode_btn)
                state_n = (state == PG_SW) ? PG_TIME : page_t'(state + 2'd1);
        end else if (alert)
            acnt_n = 8'(ALERT_TICKS);
        else if (mode_btn) begin
            state_n = saved;
            acnt_n  = '0;
        end else if (tick) begin
            acnt_n = acnt - 8'd1;
            if (acnt == 8'd1)
                state_n = saved;
        end
    end

    // a fresh edit always starts on the visible half so the user sees the digits first
    assign restart  = (edit_active & ~edit_q) | (edit_field != field_q);
    assign wrap     = bcnt == 32'(BLINK_DIV - 1);
    assign bcnt_n   = (restart | wrap) ? '0 : bcnt + 32'd1;
    assign hidden_n = restart ? 1'b0 : hidden ^ wrap;
    assign blank_en = edit_active && hidden_n && edit_field != 2'd3 &&
                      (state_n == PG_TIME || state_n == PG_ALARM);
    assign src = (state_n == PG_TIME)  ? time_disp  :
                 (state_n == PG_ALARM) ? alarm_disp :
                 (state_n == PG_SW)    ? sw_disp    : ALERT_MSG;

    always_comb begin
        disp_n = '0;
        for (int i = 0; i < 6; i++)
            disp_n[4*i+:4] = (src[4*i+:4] > 4'd12 ||
                              (blank_en && i / 2 == 2 - int'(edit_field))) ? 4'd0 : src[4*i+:4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= PG_TIME;
            saved        <= PG_TIME;
            acnt         <= '0;
            bcnt         <= '0;
            hidden       <= 1'b0;
            edit_q       <= 1'b0;
            field_q      <= 2'd0;
            display      <= '0;
            page         <= 2'd0;
            blink        <= 1'b0;
            alert_active <= 1'b0;
        end else begin
            state        <= state_n;
            saved        <= saved_n;
            acnt         <= acnt_n;
            bcnt         <= bcnt_n;
            hidden       <= hidden_n;
            edit_q       <= edit_active;
            field_q      <= edit_field;
            display      <= disp_n;
            page         <= state_n;
            blink        <= state_n == PG_ALERT;
            alert_active <= state_n == PG_ALERT;
        end
    end
endmodule

// File: tb/tb_fnd_page_ctrl.sv
// tb_fnd_page_ctrl: directed stimulus with a behavioural reference model and literal spot checks.
module tb_fnd_page_ctrl;
    localparam int DIV = 4;
    localparam int TCK = 3;

    logic        clk = 0, rst = 1, tick = 0, mode_btn = 0, alert = 0, edit_active = 0;
    logic [1:0]  edit_field = 0;
    logic [23:0] time_disp = 24'h345678, alarm_disp = 24'h3C3B00, sw_disp = 24'h222222;
    logic [23:0] display;
    logic        blink, alert_active;
    logic [1:0]  page;
    int          vecs = 0, errs = 0;

    fnd_page_ctrl #(.BLINK_DIV(DIV), .ALERT_TICKS(TCK), .ALERT_MSG(24'h112200)) dut (
        .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn), .alert(alert),
        .edit_active(edit_active), .edit_field(edit_field), .time_disp(time_disp),
        .alarm_disp(alarm_disp), .sw_disp(sw_disp), .display(display), .blink(blink),
        .page(page), .alert_active(alert_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: page number, saved page, ticks left, cycles since blink restart
    int          m_page, m_saved, m_rem, m_k;
    logic        m_pe;
    logic [1:0]  m_pf;
    logic [23:0] e_disp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_page = 0; m_saved = 0; m_rem = 0; m_k = 0; m_pe = 0; m_pf = 0; e_disp = 0;
        end else begin
            logic [23:0] s;
            bit hid;
            if (m_page != 3) begin
                if (alert) begin m_saved = m_page; m_page = 3; m_rem = TCK; end
                else if (mode_btn) m_page = (m_page + 1) % 3;
            end else if (alert) m_rem = TCK;
            else if (mode_btn) m_page = m_saved;
            else if (tick) begin
                m_rem--;
                if (m_rem == 0) m_page = m_saved;
            end
            m_k = ((edit_active && !m_pe) || edit_field != m_pf) ? 0 : m_k + 1;
            m_pe = edit_active; m_pf = edit_field;
            hid = ((m_k / DIV) % 2) == 1;
            s = m_page == 0 ? time_disp : m_page == 1 ? alarm_disp : m_page == 2 ? sw_disp : 24'h112200;
            for (int i = 0; i < 6; i++) begin
                bit z;
                z = s[4*i+:4] > 12 || (edit_active && hid && edit_field != 3 && m_page < 2 &&
                                       (5 - i) / 2 == int'(edit_field));
                e_disp[4*i+:4] = z ? 4'd0 : s[4*i+:4];
            end
        end
    end

    always @(negedge clk) begin
        chk("display", display, e_disp);
        chk("page", 24'(page), 24'(m_page));
        chk("blink", 24'(blink), 24'(m_page == 3));
        chk("alert_active", 24'(alert_active), 24'(m_page == 3));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit a, input bit m, input bit t);
        alert = a; mode_btn = m; tick = t;
        @(negedge clk);
        alert = 0; mode_btn = 0; tick = 0;
    endtask

    initial begin
        cyc(2);
        rst = 0;
        cyc(1);
        chk("lit_reset_disp", display, 24'h345678);
        chk("lit_reset_page", 24'(page), 24'd0);
        chk("lit_reset_blink", 24'(blink), 24'd0);
        pulse(0, 1, 0);
        chk("lit_alarm_page", 24'(page), 24'd1);
        chk("lit_alarm_disp", display, 24'h3C3B00);
        cyc(4);
        pulse(0, 1, 0);
        chk("lit_sw_disp", display, 24'h222222);
        cyc(4);
        pulse(0, 1, 0);
        chk("lit_back_time", 24'(page), 24'd0);
        time_disp = 24'h456789; edit_field = 1; edit_active = 1;
        cyc(1);
        chk("lit_edit_vis", display, 24'h456789);
        cyc(4);
        chk("lit_edit_hid", display, 24'h450089);
        cyc(1);
        edit_field = 2;
        cyc(1);
        chk("lit_field_restart", display, 24'h456789);
        cyc(4);
        chk("lit_field2_hid", display, 24'h456700);
        edit_active = 0; edit_field = 0;
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        chk("lit_alert_disp", display, 24'h112200);
        chk("lit_alert_blink", 24'(blink), 24'd1);
        pulse(0, 0, 1); pulse(0, 0, 1);
        chk("lit_alert_hold", 24'(page), 24'd3);
        pulse(0, 0, 1);
        chk("lit_alert_exit", 24'(page), 24'd1);
        pulse(1, 0, 0); pulse(0, 0, 1); pulse(0, 0, 1);
        pulse(1, 0, 0); pulse(0, 0, 1); pulse(0, 0, 1);
        chk("lit_extend_hold", 24'(page), 24'd3);
        pulse(0, 0, 1);
        chk("lit_extend_exit", 24'(page), 24'd1);
        pulse(1, 0, 0); cyc(1);
        pulse(0, 1, 0);
        chk("lit_cancel", 24'(page), 24'd1);
        pulse(0, 1, 0); pulse(0, 1, 0);
        pulse(1, 1, 0);
        chk("lit_collide", 24'(page), 24'd3);
        pulse(0, 1, 0);
        chk("lit_saved_time", 24'(page), 24'd0);
        pulse(1, 0, 0); pulse(0, 0, 1); pulse(0, 0, 1);
        pulse(1, 0, 1);
        chk("lit_alert_vs_tick", 24'(page), 24'd3);
        pulse(0, 0, 1); pulse(0, 0, 1); pulse(0, 0, 1);
        chk("lit_after_reload", 24'(page), 24'd0);
        time_disp = 24'hF3D4E5;
        cyc(1);
        chk("lit_invalid", display, 24'h030405);
        pulse(1, 0, 0);
        #2 rst = 1;
        #1;
        chk("lit_async_disp", display, 24'h000000);
        chk("lit_async_page", 24'(page), 24'd0);
        chk("lit_async_aa", 24'(alert_active), 24'd0);
        cyc(2);
        rst = 0;
        cyc(3);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/fnd_page_ctrl.md
Name: fnd_page_ctrl

Overview:
Page controller and arbiter in front of seven_segment_display. It selects which 24-bit digit word (time, alarm, stopwatch, or a temporary alert message) drives display, and it blanks the digit pair under edit at a fixed rate. It also drives the whole-display blink input during an alert. Digit code convention: 0 = blank, 1 = 'A', 2 = 'S', 3..12 = numerals 0..9; codes 13..15 are invalid.

Parameters:
BLINK_DIV, 12800, clk cycles per half-period of edit-field blinking (counter width 32 bits)
ALERT_TICKS, 10, number of tick pulses an alert message stays on screen (1..255)
ALERT_MSG, 24'h112200, digit word shown during alert ("AASS" followed by two blanks)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
tick  input  1  one-cycle time-base pulse (1 Hz domain), drives the alert timeout
mode_btn  input  1  one-cycle debounced pulse; advances or cancels pages
alert  input  1  one-cycle pulse requesting the alert page
edit_active  input  1  user is editing the current page
edit_field  input  2  0 = digits [23:16], 1 = [15:8], 2 = [7:0], 3 = none
time_disp  input  24  time page digit word
alarm_disp  input  24  alarm page digit word
sw_disp  input  24  stopwatch page digit word
display  output  24  registered digit word to seven_segment_display
blink  output  1  registered; whole-display blink enable
page  output  2  registered current page: 0 TIME, 1 ALARM, 2 STOPWATCH, 3 ALERT
alert_active  output  1  registered; high while page == 3

Behaviour:
- Reset (async, any time, including mid-alert):
  - page = TIME; display = 0; blink = 0; alert_active = 0.
  - alert counter = 0; saved page = TIME; blink counter = 0; phase = visible.
- Page FSM states: TIME, ALARM, SW, ALERT.
- Base pages (TIME, ALARM, SW):
  - mode_btn cycles TIME -> ALARM -> SW -> TIME.
  - alert pulse: save the current base page, enter ALERT, load counter = ALERT_TICKS.
  - alert and mode_btn in the same cycle: alert wins; mode_btn is ignored; the saved page is the un-advanced page.
- ALERT:
  - tick decrements the counter. A tick while the counter == 1 returns to the saved page, and the counter becomes 0.
  - mode_btn: return to the saved page immediately, with no page advance.
  - alert during ALERT reloads the counter to ALERT_TICKS; the saved page is unchanged.
  - alert together with mode_btn in ALERT: alert wins (reload, stay in ALERT).
  - alert together with an expiring tick: alert wins.
- Source select:
  - TIME -> time_disp; ALARM -> alarm_disp; SW -> sw_disp; ALERT -> ALERT_MSG.
  - Any nibble > 12 is replaced by 0 (blank) before output.
- Edit blanking:
  - Applies only when edit_active = 1, page is TIME or ALARM, and edit_field != 3.
  - During the hidden phase, both nibbles of the selected field are forced to 0. Other digits pass through.
  - Edit blanking is ignored on SW and ALERT.
- Blink counter:
  - Counts 0..BLINK_DIV-1 continuously. Phase toggles when the count == BLINK_DIV-1, and the count wraps to 0.
  - On an edit_active rising edge, or any edit_field change, the counter restarts at 0 and the phase is forced visible.
  - If the restart and the terminal count coincide, the restart wins.
- blink = 1 exactly when the next page is ALERT, else 0.
- Latency: all outputs are registered. display, page, alert_active and blink reflect inputs and state updates one clk after the triggering edge. Source data changes appear on display 1 cycle later.
- alert_active = (page == 3) always; page never holds an undefined value.

Test Plan:
- Reset then idle, time_disp = 24'h345678 -> after 1 clk: display = 24'h345678, page = 0, blink = 0, alert_active = 0.
- Three mode_btn pulses 5 cycles apart, alarm_disp = 24'h3C3B00, sw_disp = 24'h222222 -> page 1 (display 3C3B00), then 2 (222222), then 0; each change appears 1 cycle after the pulse.
- Edit blanking with BLINK_DIV = 4, page TIME, time_disp = 24'h456789, edit_active = 1, edit_field = 1:
  - Expected display: 456789 for 4 cycles, then 450089 for 4 cycles, repeating.
  - Changing edit_field to 2 mid-hidden restores visible immediately (456789) and restarts the count.
- Alert with ALERT_TICKS = 3 on the ALARM page:
  - alert pulse -> page = 3, display = 24'h112200, blink = 1.
  - After the 3rd tick -> page = 1, blink = 0.
  - A second alert after tick 2 extends the alert to 3 more ticks.
- Alert cancel and collisions:
  - mode_btn during ALERT -> returns to the saved page with no advance.
  - alert and mode_btn in the same cycle on TIME -> page = 3, saved page = TIME.
- Invalid codes and async reset:
  - time_disp = 24'hF3D4E5 -> display = 24'h030405.
  - rst asserted mid-alert, between clock edges -> outputs go to reset values immediately, without waiting for a clock edge.
